// File: rtl/ex_if.sv
// Execute-stage bundle: stall vector and ID->EX bus in, MEM/ID/data-SRAM buses out.
// The ID/pipeline side drives as master, the EX stage consumes as slave.
interface ex_if;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [140:0] ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         ex_is_load;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_bus, ex_is_load,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  stallreq_for_ex
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_bus, ex_is_load,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output stallreq_for_ex
  );
endinterface

// File: rtl/ex.sv
// Execute stage: pipeline register, one-hot ALU, data-SRAM request and a
// 32-step restoring divider that freezes the pipeline while it runs.
module ex (
  input  logic clk,
  input  logic rst,
  ex_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  logic [158:0] id_ex_q, id_ex_d;

  always_comb begin
    id_ex_d = id_ex_q;
    if (bus.stall[2] && !bus.stall[3]) begin
      id_ex_d = '0;
    end else if (!bus.stall[2]) begin
      id_ex_d = bus.id_to_ex_bus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) id_ex_q <= '0;
    else      id_ex_q <= id_ex_d;
  end

  logic [31:0] pc, inst, data1, data2;
  logic [11:0] alu_op;
  logic [2:0]  sel_alu_src1;
  logic [3:0]  sel_alu_src2;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        sel_rf_res;

  assign {pc, inst, alu_op, sel_alu_src1, sel_alu_src2, data_ram_en, data_ram_wen,
          rf_we, rf_waddr, sel_rf_res, data1, data2} = id_ex_q;

  logic unused_bits;
  assign unused_bits = ^{bus.stall[5:4], bus.stall[1:0], inst[25:16]};

  // ALU: operand selects and op selects are one-hot, combined by AND-OR
  logic [31:0] src1, src2, imm_sext, imm_zext;
  logic [31:0] sum, diff, sra_res, alu_res;
  logic        slt, sltu;

  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};

  always_comb begin
    src1 = ({32{sel_alu_src1[0]}} & data1)
         | ({32{sel_alu_src1[1]}} & pc)
         | ({32{sel_alu_src1[2]}} & {27'b0, inst[10:6]});
    src2 = ({32{sel_alu_src2[0]}} & data2)
         | ({32{sel_alu_src2[1]}} & imm_sext)
         | ({32{sel_alu_src2[2]}} & 32'd8)
         | ({32{sel_alu_src2[3]}} & imm_zext);
  end

  assign sum     = src1 + src2;
  assign diff    = src1 - src2;
  assign slt     = $signed(src1) < $signed(src2);
  assign sltu    = src1 < src2;
  assign sra_res = $signed(src2) >>> src1[4:0];

  always_comb begin
    alu_res = '0;
    alu_res = alu_res
            | ({32{alu_op[11]}} & sum)
            | ({32{alu_op[10]}} & diff)
            | ({32{alu_op[9]}}  & {31'b0, slt})
            | ({32{alu_op[8]}}  & {31'b0, sltu})
            | ({32{alu_op[7]}}  & (src1 & src2))
            | ({32{alu_op[6]}}  & ~(src1 | src2))
            | ({32{alu_op[5]}}  & (src1 | src2))
            | ({32{alu_op[4]}}  & (src1 ^ src2))
            | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
            | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
            | ({32{alu_op[1]}}  & sra_res)
            | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});
  end

  logic is_div, is_divu, div_req;
  assign is_div  = (inst[31:26] == 6'b0) && (inst[5:0] == 6'h1A);
  assign is_divu = (inst[31:26] == 6'b0) && (inst[5:0] == 6'h1B);
  assign div_req = is_div | is_divu;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] dividend_q, dividend_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        first_q, first_d;

  logic [32:0] shifted, trial;
  logic        stallreq;
  logic        hilo_we;
  logic [31:0] hi_wdata, lo_wdata;

  // quot_q starts as the dividend and shifts its bits into the remainder,
  // refilling from the bottom with quotient bits
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    first_d    = 1'b0;
    stallreq   = 1'b0;
    hilo_we    = 1'b0;
    hi_wdata   = '0;
    lo_wdata   = '0;
    shifted    = {rem_q, quot_q[31]};
    trial      = shifted - {1'b0, divisor_q};

    unique case (state_q)
      IDLE: begin
        if (div_req) begin
          stallreq   = 1'b1;
          state_d    = BUSY;
          cnt_d      = '0;
          rem_d      = '0;
          dividend_d = data1;
          quot_d     = (is_div && data1[31]) ? (~data1 + 32'd1) : data1;
          divisor_d  = (is_div && data2[31]) ? (~data2 + 32'd1) : data2;
          neg_quot_d = is_div && (data1[31] ^ data2[31]);
          neg_rem_d  = is_div && data1[31];
        end
      end
      BUSY: begin
        stallreq = 1'b1;
        if (!trial[32]) begin
          rem_d  = trial[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = shifted[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          first_d = 1'b1;
        end
      end
      DONE: begin
        hilo_we = first_q;
        if (divisor_q == '0) begin
          lo_wdata = '1;
          hi_wdata = dividend_q;
        end else begin
          lo_wdata = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
          hi_wdata = neg_rem_q  ? (~rem_q + 32'd1)  : rem_q;
        end
        if (!bus.stall[2]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      first_q    <= first_d;
    end
  end

  assign bus.stallreq_for_ex = stallreq;
  assign bus.ex_is_load      = sel_rf_res;
  assign bus.ex_to_id_bus    = {rf_we, rf_waddr, alu_res};
  assign bus.ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr,
                                alu_res, hilo_we, hi_wdata, lo_wdata};

  assign bus.data_sram_en    = data_ram_en & ~stallreq;
  assign bus.data_sram_wen   = stallreq ? 4'b0 : data_ram_wen;
  assign bus.data_sram_addr  = stallreq ? '0 : alu_res;
  assign bus.data_sram_wdata = stallreq ? '0 : data2;

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage: ALU vector table plus divider,
// stall/bubble and reset sequences.
module tb_ex;
  logic       clk;
  logic       rst;
  logic [5:0] stall_man;

  ex_if bus_if ();

  ex dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  assign bus_if.stall = bus_if.stallreq_for_ex ? 6'b001111 : stall_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        en;
    logic [3:0]  wen;
    logic        we;
    logic [4:0]  wa;
    logic        sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [158:0] mkbus(input vec_t v);
    return {v.pc, v.inst, v.op, v.s1, v.s2, v.en, v.wen, v.we, v.wa, v.sel, v.d1, v.d2};
  endfunction

  function automatic vec_t divv(input logic [31:0] inst, input logic [31:0] d1,
                                input logic [31:0] d2);
    return '{32'h0000_2000, inst, 12'h000, 3'b000, 4'b0000, 1'b1, 4'hF, 1'b0, 5'd0,
             1'b0, d1, d2, 32'h0};
  endfunction

  // called #1 after a rising edge; returns #1 after the next one
  task automatic drive(input logic [158:0] b, input logic [5:0] s);
    bus_if.id_to_ex_bus = b;
    stall_man = s;
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, input vec_t v,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    int en_bad;
    drive(mkbus(v), 6'b0);
    bus_if.id_to_ex_bus = '0;
    n = 0;
    en_bad = 0;
    while (bus_if.stallreq_for_ex && n < 100) begin
      n++;
      if (bus_if.data_sram_en || bus_if.data_sram_wen != 4'b0) en_bad++;
      @(posedge clk);
      #1;
    end
    chk({tag, " stall cycles"}, 64'(n), 64'd33);
    chk({tag, " sram forced off"}, 64'(en_bad), 64'd0);
    chk({tag, " hilo_we"}, 64'(bus_if.ex_to_mem_bus[64]), 64'd1);
    chk({tag, " lo"}, 64'(bus_if.ex_to_mem_bus[31:0]), 64'(exp_lo));
    chk({tag, " hi"}, 64'(bus_if.ex_to_mem_bus[63:32]), 64'(exp_hi));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h0000_1000, 32'h3443_000F, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd3,  1'b0, 32'h0000_00F0, 32'h0,          32'h0000_00FF};
    vecs[1]  = '{32'h0000_1004, 32'h3C01_8001, 12'h001, 3'b000, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd1,  1'b0, 32'h0,          32'h0,          32'h8001_0000};
    vecs[2]  = '{32'h0000_1008, 32'h0000_0103, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2,  1'b0, 32'h0,          32'h8000_0000, 32'hF800_0000};
    vecs[3]  = '{32'h0000_100C, 32'hAC00_0004, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,  1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1004};
    vecs[4]  = '{32'h0000_1010, 32'h0000_0023, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,  1'b0, 32'h5,          32'h7,          32'hFFFF_FFFE};
    vecs[5]  = '{32'h0000_1014, 32'h0000_002A, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'hFFFF_FFFF, 32'h1,          32'h1};
    vecs[6]  = '{32'h0000_1018, 32'h0000_002B, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd6,  1'b0, 32'hFFFF_FFFF, 32'h1,          32'h0};
    vecs[7]  = '{32'h0000_101C, 32'h0000_0027, 12'h040, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd7,  1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F};
    vecs[8]  = '{32'h0000_1020, 32'h0000_0024, 12'h080, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8,  1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00};
    vecs[9]  = '{32'h0000_1024, 32'h0000_0026, 12'h010, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd9,  1'b0, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00};
    vecs[10] = '{32'h0000_1028, 32'h0000_07C0, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd10, 1'b0, 32'h0,          32'h3,          32'h8000_0000};
    vecs[11] = '{32'h0000_102C, 32'h0000_0006, 12'h004, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'h0000_0024, 32'h8000_0000, 32'h0800_0000};
    vecs[12] = '{32'hBFC0_0000, 32'h0C00_0000, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0,          32'h0,          32'hBFC0_0008};
    vecs[13] = '{32'h0000_1030, 32'h0000_0021, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd13, 1'b0, 32'hFFFF_FFFF, 32'h2,          32'h1};
    vecs[14] = '{32'h0000_1034, 32'h0000_0021, 12'h800, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd14, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0};
    vecs[15] = '{32'h0000_1038, 32'h8C00_0008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd15, 1'b1, 32'h0000_0100, 32'h0,          32'h0000_0108};
    vecs[16] = '{32'h0000_103C, 32'h2400_FFFC, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd16, 1'b0, 32'h0000_0010, 32'h0,          32'h0000_000C};
    vecs[17] = '{32'h0000_1040, 32'h3400_8000, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd17, 1'b0, 32'h0,          32'h0,          32'h0000_8000};

    rst = 1'b1;
    stall_man = 6'b0;
    bus_if.id_to_ex_bus = mkbus(vecs[0]);
    #2 rst = 1'b0;
    #1;
    chk("reset mem_bus nonzero", 64'(bus_if.ex_to_mem_bus != '0), 64'd0);
    chk("reset id_bus", 64'(bus_if.ex_to_id_bus), 64'd0);
    chk("reset stallreq", 64'(bus_if.stallreq_for_ex), 64'd0);
    chk("reset sram_en", 64'(bus_if.data_sram_en), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset held id_bus", 64'(bus_if.ex_to_id_bus), 64'd0);
    chk("reset held is_load", 64'(bus_if.ex_is_load), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(mkbus(vecs[i]), 6'b0);
      chk($sformatf("v%0d ex_result", i), 64'(bus_if.ex_to_mem_bus[96:65]), 64'(vecs[i].exp));
      chk($sformatf("v%0d id_bus", i), 64'(bus_if.ex_to_id_bus),
          64'({vecs[i].we, vecs[i].wa, vecs[i].exp}));
      chk($sformatf("v%0d mem pc/ctl", i), 64'(bus_if.ex_to_mem_bus[140:97]),
          64'({vecs[i].pc, vecs[i].en, vecs[i].wen, vecs[i].sel, vecs[i].we, vecs[i].wa}));
      chk($sformatf("v%0d sram addr", i), 64'(bus_if.data_sram_addr), 64'(vecs[i].exp));
      chk($sformatf("v%0d sram en/wen", i), 64'({bus_if.data_sram_en, bus_if.data_sram_wen}),
          64'({vecs[i].en, vecs[i].wen}));
      chk($sformatf("v%0d sram wdata", i), 64'(bus_if.data_sram_wdata), 64'(vecs[i].d2));
      chk($sformatf("v%0d is_load", i), 64'(bus_if.ex_is_load), 64'(vecs[i].sel));
      chk($sformatf("v%0d hilo idle", i), 64'(bus_if.ex_to_mem_bus[64:0]), 64'd0);
    end

    // hold and bubble behaviour of the EX register
    drive(mkbus(vecs[0]), 6'b0);
    drive(mkbus(vecs[1]), 6'b001100);
    chk("hold keeps result", 64'(bus_if.ex_to_mem_bus[96:65]), 64'h0000_00FF);
    drive(mkbus(vecs[1]), 6'b000100);
    chk("bubble id_bus", 64'(bus_if.ex_to_id_bus), 64'd0);
    drive(mkbus(divv(32'h0000_001A, 32'h64, 32'h7)), 6'b000100);
    chk("bubbled div no stall", 64'(bus_if.stallreq_for_ex), 64'd0);
    drive('0, 6'b0);
    chk("bubbled div still idle", 64'(bus_if.stallreq_for_ex), 64'd0);

    // signed divide, then hold in DONE for one cycle
    run_div("div -7/2", divv(32'h0000_001A, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    stall_man = 6'b001100;
    @(posedge clk);
    #1;
    chk("done hold hilo_we", 64'(bus_if.ex_to_mem_bus[64]), 64'd0);
    chk("done hold lo", 64'(bus_if.ex_to_mem_bus[31:0]), 64'hFFFF_FFFD);
    chk("done hold stallreq", 64'(bus_if.stallreq_for_ex), 64'd0);
    drive('0, 6'b0);
    chk("after div hilo", 64'(bus_if.ex_to_mem_bus[64:0]), 64'd0);
    chk("after div stallreq", 64'(bus_if.stallreq_for_ex), 64'd0);

    run_div("divu by 0", divv(32'h0000_001B, 32'h0000_1234, 32'h0), 32'hFFFF_FFFF, 32'h0000_1234);
    drive('0, 6'b0);
    run_div("div 100/-7", divv(32'h0000_001A, 32'h64, 32'hFFFF_FFF9), 32'hFFFF_FFF2, 32'h2);
    drive('0, 6'b0);
    run_div("divu big/2", divv(32'h0000_001B, 32'hFFFF_FFF9, 32'h2), 32'h7FFF_FFFC, 32'h1);
    drive('0, 6'b0);
    chk("divu after hilo", 64'(bus_if.ex_to_mem_bus[64:0]), 64'd0);

    // reset asserted with the divider in BUSY, counter = 10
    begin
      int bad;
      drive(mkbus(divv(32'h0000_001A, 32'h64, 32'h7)), 6'b0);
      bus_if.id_to_ex_bus = '0;
      repeat (11) @(posedge clk);
      #1;
      chk("pre-abort stallreq", 64'(bus_if.stallreq_for_ex), 64'd1);
      rst = 1'b0;
      #1;
      chk("abort stallreq", 64'(bus_if.stallreq_for_ex), 64'd0);
      chk("abort mem_bus nonzero", 64'(bus_if.ex_to_mem_bus != '0), 64'd0);
      chk("abort sram_en", 64'(bus_if.data_sram_en), 64'd0);
      #3 rst = 1'b1;
      bad = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (bus_if.ex_to_mem_bus != '0 || bus_if.stallreq_for_ex || bus_if.ex_to_id_bus != '0)
          bad++;
      end
      chk("post-abort quiet cycles", 64'(bad), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
